uart_io_ctrl: RTL and testbench

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

---
 rtl/uart_io_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_io_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// LSU-facing UART register window with a TX FIFO feeding a valid/ready transmitter.
// Optional RX holding register enabled by defining UART_RX_BUF_EN.
module uart_io_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_addr,
  input  logic [7:0]  lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_stall,
  input  logic        uart_tx_ready,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_empty, fifo_full;
  logic            tx_wr, push, pop;
  logic [7:0]      tx_data_q;
  logic [7:0]      rx_byte;
  logic            rx_avail, rx_overrun;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign tx_wr      = lsu_req & lsu_we & (lsu_addr == 2'd0);
  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign push       = tx_wr & ~fifo_full;
  assign lsu_stall  = rst_n & tx_wr & fifo_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = SEND;
      SEND: if (uart_tx_ready && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE: pop = ~fifo_empty;
      SEND: pop = uart_tx_ready & ~fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  assign uart_tx_en   = rst_n & (state_q == SEND);
  assign uart_tx_data = tx_data_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= lsu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx_data_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_data_q <= fifo_mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef UART_RX_BUF_EN
  logic rd_rx;
  assign rd_rx = lsu_req & ~lsu_we & (lsu_addr == 2'd2);

  // A capture coinciding with a clearing read wins: byte stays available, no overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_byte    <= '0;
      rx_avail   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (uart_rx_valid) begin
      rx_byte    <= uart_rx_data;
      rx_avail   <= 1'b1;
      rx_overrun <= rd_rx ? 1'b0 : (rx_overrun | rx_avail);
    end else if (rd_rx) begin
      rx_avail   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`else
  logic rx_unused;
  assign rx_unused  = ^{uart_rx_valid, uart_rx_data};
  assign rx_byte    = '0;
  assign rx_avail   = 1'b0;
  assign rx_overrun = 1'b0;
`endif

  always_comb begin
    lsu_rdata = '0;
    if (lsu_req && !lsu_we) begin
      case (lsu_addr)
        2'd1:    lsu_rdata = {27'd0, rx_overrun, rx_avail, fifo_full, fifo_empty,
                              (state_q == SEND)};
        2'd2:    lsu_rdata = {24'd0, rx_byte};
        default: lsu_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_uart_io_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [1:0]  lsu_addr;
  logic [7:0]  lsu_wdata;
  logic [31:0] lsu_rdata;
  logic        lsu_stall;
  logic        uart_tx_ready, uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_io_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall),
    .uart_tx_ready(uart_tx_ready), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data)
  );

  // Transaction model: queued bytes, the byte on offer, and RX flags.
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  logic [7:0] m_cur = 8'h00;
  bit         m_rx_avail = 1'b0, m_rx_ovr = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;
  logic [7:0] m_sent[$];
  logic [7:0] dut_sent[$];

  always @(posedge clk) begin : model
    bit wr, rd_rx, was_busy;
    int n;
    if (rst_n === 1'b1 && uart_tx_en === 1'b1 && uart_tx_ready === 1'b1)
      dut_sent.push_back(uart_tx_data);
    if (rst_n !== 1'b1) begin
      m_q.delete();
      m_busy = 1'b0; m_cur = 8'h00;
      m_rx_avail = 1'b0; m_rx_ovr = 1'b0; m_rx_byte = 8'h00;
    end else begin
      wr       = lsu_req && lsu_we && lsu_addr == 2'd0;
      rd_rx    = lsu_req && !lsu_we && lsu_addr == 2'd2;
      n        = m_q.size();
      was_busy = m_busy;
      if (was_busy && uart_tx_ready) begin
        m_sent.push_back(m_cur);
        m_busy = 1'b0;
      end
      if ((!was_busy || uart_tx_ready) && n > 0) begin
        m_cur  = m_q.pop_front();
        m_busy = 1'b1;
      end
      if (wr && n < DEPTH) m_q.push_back(lsu_wdata);
`ifdef UART_RX_BUF_EN
      if (uart_rx_valid) begin
        m_rx_ovr   = rd_rx ? 1'b0 : (m_rx_ovr | m_rx_avail);
        m_rx_avail = 1'b1;
        m_rx_byte  = uart_rx_data;
      end else if (rd_rx) begin
        m_rx_avail = 1'b0;
        m_rx_ovr   = 1'b0;
      end
`else
      if (rd_rx) m_rx_avail = 1'b0;
`endif
    end
  end

  function automatic logic [31:0] exp_status();
    return {27'd0, m_rx_ovr, m_rx_avail, (m_q.size() == DEPTH), (m_q.size() == 0), m_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 2'd0; lsu_wdata = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] d);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 2'd0; lsu_wdata = d;
  endtask

  task automatic bus_read(input logic [1:0] a);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = a; lsu_wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    bus_write(8'hEE);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (lsu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", lsu_stall); end
      tick();
      checks++;
      if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", uart_tx_en); end
    end
    checks++;
    if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); end
    bus_idle();
    rst_n = 1'b1;
    tick();
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 2", lsu_rdata); end
    lsu_req = 1'b0; #1;
    checks++;
    if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL rdata_noreq: got %h want 0", lsu_rdata); end
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 2'd1; lsu_wdata = 8'h41; #1;
    checks++;
    if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL rdata_write: got %h want 0", lsu_rdata); end
    tick();
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL status_after_bad_write: got %h want 2", lsu_rdata); end
    bus_idle();
    tick();
  endtask

  task automatic test_single();
    dut_sent.delete(); m_sent.delete();
    uart_tx_ready = 1'b1;
    bus_write(8'h41);
    tick();
    bus_idle(); #1;
    checks++;
    if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_e: got %b want 0", uart_tx_en); end
    tick();
    checks++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h41) begin
      errors++; $display("FAIL single_en_e1: got en=%b data=%h want en=1 data=41", uart_tx_en, uart_tx_data);
    end
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h3) begin errors++; $display("FAIL single_status_busy: got %h want 3", lsu_rdata); end
    tick();
    checks++;
    if (uart_tx_en !== 1'b0 || lsu_rdata !== 32'h2) begin
      errors++; $display("FAIL single_done: got en=%b status=%h want en=0 status=2", uart_tx_en, lsu_rdata);
    end
    bus_idle();
    checks++;
    if (dut_sent.size() != 1 || dut_sent[0] !== 8'h41) begin
      errors++; $display("FAIL single_sent: got %0d bytes want one byte 41", dut_sent.size());
    end
  endtask

  task automatic test_fill_stall();
    int guard;
    dut_sent.delete(); m_sent.delete();
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus_write(8'(i)); #1;
      checks++;
      if (lsu_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b want 0", i, lsu_stall); end
      tick();
    end
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h5 || uart_tx_en !== 1'b1 || uart_tx_data !== 8'h01) begin
      errors++; $display("FAIL fill_full: got status=%h en=%b data=%h want 5/1/01", lsu_rdata, uart_tx_en, uart_tx_data);
    end
    bus_write(8'h06);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (lsu_stall !== 1'b1) begin errors++; $display("FAIL sixth_stall: got %b want 1", lsu_stall); end
      tick();
    end
    uart_tx_ready = 1'b1; #1;
    checks++;
    if (lsu_stall !== 1'b1) begin errors++; $display("FAIL stall_with_pop: got %b want 1", lsu_stall); end
    tick();
    checks++;
    if (lsu_stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", lsu_stall); end
    tick();
    bus_idle();
    guard = 0;
    while (dut_sent.size() < 6 && guard < 20) begin
      checks++;
      if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL b2b_en_drop: got %b want 1", uart_tx_en); end
      tick();
      guard++;
    end
    checks++;
    if (dut_sent.size() != 6) begin
      errors++; $display("FAIL b2b_count: got %0d bytes want 6", dut_sent.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dut_sent[i] !== 8'(i + 1)) begin
          errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, dut_sent[i], 8'(i + 1));
        end
      end
    end
    bus_read(2'd1); #1;
    checks++;
    if (uart_tx_en !== 1'b0 || lsu_rdata !== 32'h2) begin
      errors++; $display("FAIL b2b_idle: got en=%b status=%h want 0/2", uart_tx_en, lsu_rdata);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid_send();
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_write(8'hA1 + 8'(i));
      tick();
    end
    bus_idle(); #1;
    checks++;
    if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL mid_send_busy: got %b want 1", uart_tx_en); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got en=%b data=%h want 0/00", uart_tx_en, uart_tx_data);
    end
    rst_n = 1'b1;
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL mid_reset_status: got %h want 2", lsu_rdata); end
    dut_sent.delete(); m_sent.delete();
    uart_tx_ready = 1'b1;
    bus_write(8'h55);
    tick();
    bus_idle();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (dut_sent.size() != 1 || dut_sent[0] !== 8'h55) begin
      errors++; $display("FAIL mid_reset_sent: got %0d bytes (first %h) want one byte 55",
                         dut_sent.size(), dut_sent.size() > 0 ? dut_sent[0] : 8'h00);
    end
  endtask

  task automatic test_rx();
`ifdef UART_RX_BUF_EN
    uart_rx_valid = 1'b1; uart_rx_data = 8'h69;
    tick();
    uart_rx_valid = 1'b0;
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'hA) begin errors++; $display("FAIL rx_avail: got %h want a", lsu_rdata); end
    bus_read(2'd2); #1;
    checks++;
    if (lsu_rdata !== 32'h69) begin errors++; $display("FAIL rx_data: got %h want 69", lsu_rdata); end
    tick();
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL rx_cleared: got %h want 2", lsu_rdata); end
    bus_idle();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h11; tick();
    uart_rx_data = 8'h22; tick();
    uart_rx_valid = 1'b0;
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h1A) begin errors++; $display("FAIL rx_overrun: got %h want 1a", lsu_rdata); end
    bus_read(2'd2); #1;
    checks++;
    if (lsu_rdata !== 32'h22) begin errors++; $display("FAIL rx_overwrite: got %h want 22", lsu_rdata); end
    tick();
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL rx_ovr_clear: got %h want 2", lsu_rdata); end
    bus_idle();
    uart_rx_valid = 1'b1; uart_rx_data = 8'h33; tick();
    uart_rx_data = 8'h44;
    bus_read(2'd2); #1;
    checks++;
    if (lsu_rdata !== 32'h33) begin errors++; $display("FAIL rx_same_edge_read: got %h want 33", lsu_rdata); end
    tick();
    uart_rx_valid = 1'b0;
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'hA) begin errors++; $display("FAIL rx_same_edge_status: got %h want a", lsu_rdata); end
    bus_read(2'd2); #1;
    checks++;
    if (lsu_rdata !== 32'h44) begin errors++; $display("FAIL rx_same_edge_byte: got %h want 44", lsu_rdata); end
    tick();
    bus_idle();
`else
    uart_rx_valid = 1'b1; uart_rx_data = 8'h69;
    tick();
    tick();
    uart_rx_valid = 1'b0;
    bus_read(2'd1); #1;
    checks++;
    if (lsu_rdata !== 32'h2) begin errors++; $display("FAIL rx_off_status: got %h want 2", lsu_rdata); end
    bus_read(2'd2); #1;
    checks++;
    if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL rx_off_data: got %h want 0", lsu_rdata); end
    tick();
    bus_idle();
`endif
  endtask

  task automatic test_random();
    int op, guard;
    bit held;
    logic [31:0] exp_rd;
    dut_sent.delete(); m_sent.delete();
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        op = $urandom_range(0, 3);
        case (op)
          1:       bus_write(8'($urandom));
          2:       bus_read(2'd1);
          3:       bus_read(2'd2);
          default: begin bus_idle(); lsu_addr = 2'($urandom); end
        endcase
      end
      uart_tx_ready = ($urandom_range(0, 2) != 0);
      uart_rx_valid = ($urandom_range(0, 3) == 0);
      uart_rx_data  = 8'($urandom);
      #1;
      exp_rd = 32'h0;
      if (op == 2) exp_rd = exp_status();
`ifdef UART_RX_BUF_EN
      if (op == 3) exp_rd = {24'd0, m_rx_byte};
`endif
      checks++;
      if (lsu_stall !== (op == 1 && m_q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, lsu_stall, (op == 1 && m_q.size() == DEPTH));
      end
      checks++;
      if (uart_tx_en !== m_busy) begin
        errors++; $display("FAIL rnd_tx_en c=%0d: got %b want %b", c, uart_tx_en, m_busy);
      end
      if (m_busy) begin
        checks++;
        if (uart_tx_data !== m_cur) begin
          errors++; $display("FAIL rnd_tx_data c=%0d: got %h want %h", c, uart_tx_data, m_cur);
        end
      end
      checks++;
      if (lsu_rdata !== exp_rd) begin
        errors++; $display("FAIL rnd_rdata c=%0d op=%0d: got %h want %h", c, op, lsu_rdata, exp_rd);
      end
      held = lsu_stall;
      tick();
    end
    bus_idle();
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b1;
    guard = 0;
    while ((m_busy || m_q.size() != 0) && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    checks++;
    if (guard >= 50) begin errors++; $display("FAIL rnd_drain: model still busy after %0d cycles", guard); end
    checks++;
    if (dut_sent.size() != m_sent.size()) begin
      errors++; $display("FAIL rnd_sent_count: got %0d want %0d", dut_sent.size(), m_sent.size());
    end else begin
      for (int i = 0; i < m_sent.size(); i++) begin
        checks++;
        if (dut_sent[i] !== m_sent[i]) begin
          errors++; $display("FAIL rnd_sent[%0d]: got %h want %h", i, dut_sent[i], m_sent[i]);
        end
      end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_single();
    test_fill_stall();
    test_reset_mid_send();
    test_rx();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
